// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared write-back types and default widths
package wb_pkg;

   localparam int WB_XLEN       = 64;
   localparam int WB_REG_ADDR_W = 5;

   typedef struct packed {
      logic [WB_REG_ADDR_W-1:0] rd;
      logic [WB_XLEN-1:0]       data;
   } wb_entry_t;

endpackage

// File: rtl/wb_chan_fifo.sv
// rtl/wb_chan_fifo.sv - per-channel write-back result FIFO
// Optional WB_PENDING_MASK_EN exposes the rd of every valid slot.
module wb_chan_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      push,
   input  wb_entry_t push_entry,
   input  logic      pop,
   output wb_entry_t head,
   output logic      full,
   output logic      empty
`ifdef WB_PENDING_MASK_EN
   ,
   output logic [DEPTH-1:0]                     slot_valid,
   output logic [DEPTH-1:0][WB_REG_ADDR_W-1:0]  slot_rd
`endif
);

   localparam int AW = $clog2(DEPTH);

   wb_entry_t     mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr[AW-1:0]] <= push_entry;
   end

`ifdef WB_PENDING_MASK_EN
   logic [AW:0] count;
   assign count = wr_ptr - rd_ptr;

   // A slot is live when its distance from the read index is below the occupancy.
   always_comb begin
      logic [AW-1:0] off;
      off        = '0;
      slot_valid = '0;
      slot_rd    = '0;
      for (int k = 0; k < DEPTH; k++) begin
         off           = AW'(k) - rd_ptr[AW-1:0];
         slot_valid[k] = ({1'b0, off} < count);
         slot_rd[k]    = mem[k].rd;
      end
   end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin multi-channel write-back arbiter
// Optional WB_PENDING_MASK_EN adds the pending_mask hazard output.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int XLEN       = WB_XLEN,
   parameter int NUM_CH     = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int REG_ADDR_W = WB_REG_ADDR_W
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_CH-1:0]            ch_valid,
   output logic [NUM_CH-1:0]            ch_ready,
   input  logic [NUM_CH-1:0]            ch_wen,
   input  logic [NUM_CH*REG_ADDR_W-1:0] ch_rd,
   input  logic [NUM_CH*XLEN-1:0]       ch_data,
   input  logic                         wb_stall,
   output logic [XLEN-1:0]              write_data,
   output logic [REG_ADDR_W-1:0]        write_reg,
   output logic                         write_enable
`ifdef WB_PENDING_MASK_EN
   ,
   output logic [2**REG_ADDR_W-1:0]     pending_mask
`endif
);

   localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] empty;
   logic [NUM_CH-1:0] push_vec;
   logic [NUM_CH-1:0] pop_vec;
   wb_entry_t         heads [NUM_CH];
   wb_entry_t         head_sel;

   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  grant_idx;
   logic              grant_any;
   logic              do_pop;

`ifdef WB_PENDING_MASK_EN
   logic [FIFO_DEPTH-1:0]                    slot_valid_all [NUM_CH];
   logic [FIFO_DEPTH-1:0][WB_REG_ADDR_W-1:0] slot_rd_all    [NUM_CH];
`endif

   assign ch_ready = ~full;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         wb_entry_t in_entry;
         logic [REG_ADDR_W-1:0] in_rd;

         assign in_rd         = ch_rd[gi*REG_ADDR_W +: REG_ADDR_W];
         assign in_entry.rd   = in_rd;
         assign in_entry.data = ch_data[gi*XLEN +: XLEN];
         // Non-writing results and x0 targets are acknowledged but never stored.
         assign push_vec[gi]  = ch_valid[gi] && !full[gi] && ch_wen[gi] && (in_rd != '0);

         wb_chan_fifo #(
            .DEPTH (FIFO_DEPTH)
         ) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .push       (push_vec[gi]),
            .push_entry (in_entry),
            .pop        (pop_vec[gi]),
            .head       (heads[gi]),
            .full       (full[gi]),
            .empty      (empty[gi])
`ifdef WB_PENDING_MASK_EN
            ,
            .slot_valid (slot_valid_all[gi]),
            .slot_rd    (slot_rd_all[gi])
`endif
         );
      end
   endgenerate

   // Scan from rr_ptr and take the first non-empty channel.
   always_comb begin
      int c;
      c         = 0;
      grant_any = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         c = (int'(rr_ptr) + k) % NUM_CH;
         if (!grant_any && !empty[c]) begin
            grant_any = 1'b1;
            grant_idx = PTR_W'(c);
         end
      end
   end

   assign do_pop   = grant_any && !wb_stall;
   assign head_sel = heads[grant_idx];

   always_comb begin
      pop_vec = '0;
      for (int i = 0; i < NUM_CH; i++)
         pop_vec[i] = do_pop && (int'(grant_idx) == i);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr       <= '0;
         write_data   <= '0;
         write_reg    <= '0;
         write_enable <= 1'b0;
      end else begin
         write_enable <= do_pop;
         if (do_pop) begin
            write_data <= head_sel.data;
            write_reg  <= head_sel.rd;
            rr_ptr     <= PTR_W'((int'(grant_idx) + 1) % NUM_CH);
         end
      end
   end

`ifdef WB_PENDING_MASK_EN
   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < NUM_CH; i++)
         for (int k = 0; k < FIFO_DEPTH; k++)
            if (slot_valid_all[i][k])
               pending_mask[slot_rd_all[i][k]] = 1'b1;
      if (write_enable)
         pending_mask[write_reg] = 1'b1;
      pending_mask[0] = 1'b0;
   end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized queue-model bench for wb_arbiter
module tb_wb_arbiter;

   localparam int NCH   = 3;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [4:0]  rd;
      logic [63:0] data;
   } ent_t;

   logic           clk = 1'b0;
   logic           reset;
   logic [2:0]     ch_valid;
   logic [2:0]     ch_ready;
   logic [2:0]     ch_wen;
   logic [14:0]    ch_rd;
   logic [191:0]   ch_data;
   logic           wb_stall;
   logic [63:0]    write_data;
   logic [4:0]     write_reg;
   logic           write_enable;
`ifdef WB_PENDING_MASK_EN
   logic [31:0]    pending_mask;
`endif

   ent_t           mq [NCH][$];
   int             rr;
   logic           exp_we;
   logic [4:0]     exp_reg;
   logic [63:0]    exp_data;
   int             n_total = 0;
   int             n_pass  = 0;

   wb_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .ch_valid     (ch_valid),
      .ch_ready     (ch_ready),
      .ch_wen       (ch_wen),
      .ch_rd        (ch_rd),
      .ch_data      (ch_data),
      .wb_stall     (wb_stall),
      .write_data   (write_data),
      .write_reg    (write_reg),
      .write_enable (write_enable)
`ifdef WB_PENDING_MASK_EN
      ,
      .pending_mask (pending_mask)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++)
         mq[i].delete();
      rr       = 0;
      exp_we   = 1'b0;
      exp_reg  = '0;
      exp_data = '0;
   endtask

   // One clock of the reference: ready from pre-edge occupancy, pop, then push.
   task automatic model_step();
      bit   acc [NCH];
      ent_t e;
      int   c;
      for (int i = 0; i < NCH; i++)
         acc[i] = ch_valid[i] && (mq[i].size() < DEPTH);
      exp_we = 1'b0;
      if (!wb_stall) begin
         for (int k = 0; k < NCH; k++) begin
            c = (rr + k) % NCH;
            if (!exp_we && mq[c].size() > 0) begin
               e        = mq[c].pop_front();
               exp_we   = 1'b1;
               exp_reg  = e.rd;
               exp_data = e.data;
               rr       = (c + 1) % NCH;
            end
         end
      end
      for (int i = 0; i < NCH; i++) begin
         if (acc[i] && ch_wen[i] && ch_rd[i*5 +: 5] != 5'd0) begin
            e.rd   = ch_rd[i*5 +: 5];
            e.data = ch_data[i*64 +: 64];
            mq[i].push_back(e);
         end
      end
   endtask

   task automatic check_outputs();
      logic [2:0] exp_ready;
      for (int i = 0; i < NCH; i++)
         exp_ready[i] = (mq[i].size() < DEPTH);
      chk("write_enable", 64'(write_enable), 64'(exp_we));
      chk("write_reg",    64'(write_reg),    64'(exp_reg));
      chk("write_data",   write_data,        exp_data);
      chk("ch_ready",     64'(ch_ready),     64'(exp_ready));
`ifdef WB_PENDING_MASK_EN
      begin
         logic [31:0] m;
         m = '0;
         for (int i = 0; i < NCH; i++)
            foreach (mq[i][j])
               m[mq[i][j].rd] = 1'b1;
         if (exp_we)
            m[exp_reg] = 1'b1;
         m[0] = 1'b0;
         chk("pending_mask", 64'(pending_mask), 64'(m));
      end
`endif
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input logic stall);
      ch_valid = '0;
      ch_wen   = '0;
      ch_rd    = '0;
      ch_data  = '0;
      wb_stall = stall;
   endtask

   task automatic push_one(input int ch, input logic [4:0] rd, input logic [63:0] data,
                           input logic wen);
      ch_valid[ch]         = 1'b1;
      ch_wen[ch]           = wen;
      ch_rd[ch*5 +: 5]     = rd;
      ch_data[ch*64 +: 64] = data;
   endtask

   initial begin
      reset = 1'b1;
      idle(1'b0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_outputs();
      reset = 1'b0;

      // single push: write appears two edges later
      push_one(0, 5'd5, 64'hDEAD, 1'b1);
      cycle();
      idle(1'b0);
      for (int n = 0; n < 3; n++) cycle();

      // two simultaneous bursts
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < NCH; i++)
            push_one(i, 5'(i + 1), 64'(100 * b + i), 1'b1);
         cycle();
         idle(1'b0);
         for (int n = 0; n < 4; n++) cycle();
      end

      // fill channel 0 under stall, then one rejected push, then drain
      idle(1'b1);
      for (int n = 0; n < 5; n++) begin
         push_one(0, 5'(10 + n), 64'(1000 + n), 1'b1);
         cycle();
      end
      idle(1'b0);
      for (int n = 0; n < 6; n++) cycle();

      // dropped transfers: wen=0 and rd=0
      for (int n = 0; n < 4; n++) begin
         push_one(n % NCH, 5'(n + 20), 64'hBAD, 1'b0);
         push_one((n + 1) % NCH, 5'd0, 64'hBAD0, 1'b1);
         cycle();
      end
      idle(1'b0);
      for (int n = 0; n < 3; n++) cycle();

      // reset with two entries buffered
      idle(1'b1);
      push_one(1, 5'd7, 64'h77, 1'b1);
      push_one(2, 5'd9, 64'h99, 1'b1);
      cycle();
      idle(1'b0);
      cycle();
      reset = 1'b1;
      model_reset();
      #1;
      check_outputs();
      @(posedge clk);
      @(negedge clk);
      check_outputs();
      reset = 1'b0;
      for (int n = 0; n < 4; n++) cycle();

      // randomized traffic, heavy stall first then light
      for (int n = 0; n < 3000; n++) begin
         ch_valid = 3'($urandom_range(0, 7));
         ch_wen   = 3'($urandom_range(0, 7) | $urandom_range(0, 7));
         ch_rd    = 15'($urandom());
         for (int i = 0; i < NCH; i++)
            ch_data[i*64 +: 64] = {$urandom(), $urandom()};
         wb_stall = (n < 1000) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 3) == 0);
         cycle();
      end
      idle(1'b0);
      for (int n = 0; n < 20; n++) cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
